// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC generation, ROM address drive and a small {pc, instr} queue
// presented to decode over a valid/ready handshake, with redirect flush and fetch-fault detect.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_SIZE  = 1024,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_instr_o,
    output logic [31:0] out_pc_o,
    output logic        fault_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [0:0] {StRun, StFault} state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]       pc_mem_q    [FIFO_DEPTH];
    logic [31:0]       instr_mem_q [FIFO_DEPTH];

    logic [32:0] pc_end;
    logic        pc_legal;
    logic        full;
    logic        pop;
    logic        can_fetch;
    logic        push;

    // 33-bit end address so a PC near 2^32 cannot wrap into range
    assign pc_end    = {1'b0, pc_q} + 33'd3;
    assign pc_legal  = (pc_q[1:0] == 2'b00) && (pc_end < 33'(IMEM_SIZE));
    assign full      = (count_q == CntW'(FIFO_DEPTH));
    assign pop       = out_valid_o && out_ready_i;
    assign can_fetch = (state_q == StRun) && !redirect_valid_i && (!full || pop);
    assign push      = can_fetch && pc_legal;

    assign imem_addr_o = (pc_legal && (state_q == StRun)) ? pc_q : 32'h0;
    assign out_valid_o = (count_q != '0);
    assign out_pc_o    = pc_mem_q[rd_ptr_q];
    assign out_instr_o = instr_mem_q[rd_ptr_q];
    assign fault_o     = (state_q == StFault);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (redirect_valid_i) begin
            state_d  = StRun;
            pc_d     = redirect_pc_i;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (push) begin
                pc_d     = pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (can_fetch && !pc_legal) begin
                state_d = StFault;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StRun;
            pc_q     <= RESET_PC;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Storage is reset too so out_pc/out_instr read zero while the queue is empty after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem_q[i]    <= 32'h0;
                instr_mem_q[i] <= 32'h0;
            end
        end else if (push) begin
            pc_mem_q[wr_ptr_q]    <= pc_q;
            instr_mem_q[wr_ptr_q] <= imem_instr_i;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch; ROM word i holds value i.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;

    int n_checks = 0;
    int n_pass   = 0;

    instr_fetch #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_SIZE  (1024),
        .FIFO_DEPTH (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_addr_o      (imem_addr),
        .imem_instr_i     (imem_instr),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .out_valid_o      (out_valid),
        .out_ready_i      (out_ready),
        .out_instr_o      (out_instr),
        .out_pc_o         (out_pc),
        .fault_o          (fault)
    );

    assign imem_instr = {2'b00, imem_addr[31:2]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic ready);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = ready;
        step();
        rst_n = 1'b1;
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #3;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (fault !== 1'b0) $display("FAIL rst_fault got %b want 0", fault); else n_pass++;
        n_checks++; if (out_pc !== 32'h0) $display("FAIL rst_pc got %h want 0", out_pc); else n_pass++;
        n_checks++; if (out_instr !== 32'h0) $display("FAIL rst_instr got %h want 0", out_instr); else n_pass++;
        n_checks++; if (imem_addr !== 32'h0) $display("FAIL rst_addr got %h want 0", imem_addr); else n_pass++;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        apply_reset(1'b1);
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_instr !== 32'(k))
                $display("FAIL stream[%0d] got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                         k, out_valid, out_pc, out_instr, 32'(4 * k), 32'(k));
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        apply_reset(1'b0);
        step();
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'h0 || imem_addr !== 32'h8)
                $display("FAIL bp_hold[%0d] got v=%b pc=%h addr=%h want v=1 pc=0 addr=8",
                         k, out_valid, out_pc, imem_addr);
            else n_pass++;
        end
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_instr !== 32'(k))
                $display("FAIL bp_drain[%0d] got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h",
                         k, out_valid, out_pc, out_instr, 32'(4 * k), 32'(k));
            else n_pass++;
            step();
        end
    endtask

    task automatic test_redirect();
        apply_reset(1'b0);
        step();
        step();
        do_redirect(32'h100);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL redir_flush got v=%b want 0", out_valid); else n_pass++;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== 32'd64)
            $display("FAIL redir_first got v=%b pc=%h instr=%h want v=1 pc=100 instr=40",
                     out_valid, out_pc, out_instr);
        else n_pass++;
    endtask

    task automatic test_end_of_mem();
        apply_reset(1'b1);
        do_redirect(32'h3F0);
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(32'h3F0 + 4 * k) || fault !== 1'b0)
                $display("FAIL eom_seq[%0d] got v=%b pc=%h f=%b want v=1 pc=%h f=0",
                         k, out_valid, out_pc, fault, 32'(32'h3F0 + 4 * k));
            else n_pass++;
        end
        n_checks++; if (imem_addr !== 32'h0) $display("FAIL eom_addr0 got %h want 0", imem_addr); else n_pass++;
        step();
        n_checks++;
        if (fault !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 32'h0)
            $display("FAIL eom_fault got f=%b v=%b addr=%h want f=1 v=0 addr=0",
                     fault, out_valid, imem_addr);
        else n_pass++;
        step();
        step();
        n_checks++;
        if (fault !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL eom_stay got f=%b v=%b want f=1 v=0", fault, out_valid);
        else n_pass++;
        do_redirect(32'h0);
        n_checks++; if (fault !== 1'b0) $display("FAIL eom_clear got f=%b want 0", fault); else n_pass++;
        step();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h0)
            $display("FAIL eom_resume got v=%b pc=%h instr=%h want v=1 pc=0 instr=0",
                     out_valid, out_pc, out_instr);
        else n_pass++;
    endtask

    task automatic test_misaligned();
        apply_reset(1'b1);
        do_redirect(32'h102);
        n_checks++;
        if (fault !== 1'b0 || out_valid !== 1'b0 || imem_addr !== 32'h0)
            $display("FAIL mis_first got f=%b v=%b addr=%h want f=0 v=0 addr=0",
                     fault, out_valid, imem_addr);
        else n_pass++;
        step();
        n_checks++;
        if (fault !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 32'h0)
            $display("FAIL mis_fault got f=%b v=%b addr=%h want f=1 v=0 addr=0",
                     fault, out_valid, imem_addr);
        else n_pass++;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || imem_addr === 32'h102)
            $display("FAIL mis_hold got v=%b addr=%h want v=0 addr!=102", out_valid, imem_addr);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        apply_reset(1'b0);
        step();
        step();
        n_checks++; if (out_valid !== 1'b1) $display("FAIL ar_pre got v=%b want 1", out_valid); else n_pass++;
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'h0 || imem_addr !== 32'h0)
            $display("FAIL ar_now got v=%b pc=%h addr=%h want v=0 pc=0 addr=0",
                     out_valid, out_pc, imem_addr);
        else n_pass++;
        out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(4 * k))
                $display("FAIL ar_restart[%0d] got v=%b pc=%h want v=1 pc=%h",
                         k, out_valid, out_pc, 32'(4 * k));
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_end_of_mem();
        test_misaligned();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
